// File: rtl/m_inter_tx_arbiter.sv
// Packet-level round-robin merge of the R and B response streams into one registered TX stream.
// Optional per-source packet counters and a stall counter are enabled with M_INTER_TX_ARB_STATS_EN.
module m_inter_tx_arbiter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH*8-1:0] r_channel,
  input  logic [DATA_WIDTH-1:0]   r_channel_keep,
  input  logic                    r_channel_last,
  input  logic [3:0]              r_channel_connection_id,
  input  logic [12:0]             r_channel_byte_num,
  input  logic                    r_channel_valid,
  output logic                    r_channel_ready,
  input  logic [DATA_WIDTH*8-1:0] b_channel,
  input  logic [DATA_WIDTH-1:0]   b_channel_keep,
  input  logic                    b_channel_last,
  input  logic [3:0]              b_channel_connection_id,
  input  logic [12:0]             b_channel_byte_num,
  input  logic                    b_channel_valid,
  output logic                    b_channel_ready,
  output logic [DATA_WIDTH*8-1:0] tx_data,
  output logic [DATA_WIDTH-1:0]   tx_keep,
  output logic                    tx_last,
  output logic [3:0]              tx_connection_id,
  output logic [12:0]             tx_byte_num,
  output logic                    tx_src,
  output logic                    tx_valid,
  input  logic                    tx_ready
`ifdef M_INTER_TX_ARB_STATS_EN
  ,
  output logic [31:0]             r_pkt_cnt,
  output logic [31:0]             b_pkt_cnt,
  output logic [31:0]             stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, R_BUSY, B_BUSY} state_t;

  state_t state;
  logic   last_grant;
  logic   load;
  logic   grant_r;
  logic   grant_b;
  logic   accept_r;
  logic   accept_b;

  // Grant is decided in the same cycle the first beat is presented, so no bubble is spent arbitrating.
  always_comb begin
    grant_r = 1'b0;
    grant_b = 1'b0;
    case (state)
      IDLE: begin
        if (r_channel_valid && b_channel_valid) begin
          grant_r = last_grant;
          grant_b = ~last_grant;
        end else begin
          grant_r = r_channel_valid;
          grant_b = b_channel_valid;
        end
      end
      R_BUSY:  grant_r = 1'b1;
      B_BUSY:  grant_b = 1'b1;
      default: begin
        grant_r = 1'b0;
        grant_b = 1'b0;
      end
    endcase
  end

  assign load            = ~tx_valid | tx_ready;
  assign r_channel_ready = load & grant_r & ~reset;
  assign b_channel_ready = load & grant_b & ~reset;
  assign accept_r        = r_channel_ready & r_channel_valid;
  assign accept_b        = b_channel_ready & b_channel_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      tx_valid         <= 1'b0;
      tx_data          <= '0;
      tx_keep          <= '0;
      tx_last          <= 1'b0;
      tx_connection_id <= '0;
      tx_byte_num      <= '0;
      tx_src           <= 1'b0;
    end else begin
      if (accept_r) begin
        tx_valid         <= 1'b1;
        tx_data          <= r_channel;
        tx_keep          <= r_channel_keep;
        tx_last          <= r_channel_last;
        tx_connection_id <= r_channel_connection_id;
        tx_byte_num      <= r_channel_byte_num;
        tx_src           <= 1'b0;
      end else if (accept_b) begin
        tx_valid         <= 1'b1;
        tx_data          <= b_channel;
        tx_keep          <= b_channel_keep;
        tx_last          <= b_channel_last;
        tx_connection_id <= b_channel_connection_id;
        tx_byte_num      <= b_channel_byte_num;
        tx_src           <= 1'b1;
      end else if (load) begin
        tx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept_r) begin
            last_grant <= 1'b0;
            state      <= r_channel_last ? IDLE : R_BUSY;
          end else if (accept_b) begin
            last_grant <= 1'b1;
            state      <= b_channel_last ? IDLE : B_BUSY;
          end
        end
        R_BUSY: if (accept_r && r_channel_last) state <= IDLE;
        B_BUSY: if (accept_b && b_channel_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef M_INTER_TX_ARB_STATS_EN
  // Packet counters wrap naturally; the stall counter saturates so long stalls stay visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_cnt <= '0;
      b_pkt_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept_r && r_channel_last) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (accept_b && b_channel_last) b_pkt_cnt <= b_pkt_cnt + 32'd1;
      if (tx_valid && !tx_ready && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_m_inter_tx_arbiter.sv
// Self-checking bench for m_inter_tx_arbiter: per-source packet scoreboard plus directed ordering checks.
// The stats section is compiled only when M_INTER_TX_ARB_STATS_EN is defined.
module tb_m_inter_tx_arbiter;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [3:0]   cid;
    logic [12:0]  bn;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] r_channel = '0;
  logic [15:0]  r_channel_keep = '0;
  logic         r_channel_last = 1'b0;
  logic [3:0]   r_channel_connection_id = '0;
  logic [12:0]  r_channel_byte_num = '0;
  logic         r_channel_valid = 1'b0;
  logic         r_channel_ready;
  logic [127:0] b_channel = '0;
  logic [15:0]  b_channel_keep = '0;
  logic         b_channel_last = 1'b0;
  logic [3:0]   b_channel_connection_id = '0;
  logic [12:0]  b_channel_byte_num = '0;
  logic         b_channel_valid = 1'b0;
  logic         b_channel_ready;
  logic [127:0] tx_data;
  logic [15:0]  tx_keep;
  logic         tx_last;
  logic [3:0]   tx_connection_id;
  logic [12:0]  tx_byte_num;
  logic         tx_src;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
`ifdef M_INTER_TX_ARB_STATS_EN
  logic [31:0]  r_pkt_cnt;
  logic [31:0]  b_pkt_cnt;
  logic [31:0]  stall_cnt;
`endif

  m_inter_tx_arbiter #(.DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .r_channel(r_channel), .r_channel_keep(r_channel_keep), .r_channel_last(r_channel_last),
    .r_channel_connection_id(r_channel_connection_id), .r_channel_byte_num(r_channel_byte_num),
    .r_channel_valid(r_channel_valid), .r_channel_ready(r_channel_ready),
    .b_channel(b_channel), .b_channel_keep(b_channel_keep), .b_channel_last(b_channel_last),
    .b_channel_connection_id(b_channel_connection_id), .b_channel_byte_num(b_channel_byte_num),
    .b_channel_valid(b_channel_valid), .b_channel_ready(b_channel_ready),
    .tx_data(tx_data), .tx_keep(tx_keep), .tx_last(tx_last), .tx_connection_id(tx_connection_id),
    .tx_byte_num(tx_byte_num), .tx_src(tx_src), .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef M_INTER_TX_ARB_STATS_EN
    , .r_pkt_cnt(r_pkt_cnt), .b_pkt_cnt(b_pkt_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  beat_t r_q[$];
  beat_t b_q[$];
  beat_t r_exp[$];
  beat_t b_exp[$];
  int    out_src[$];
  int    out_cyc[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    r_en, b_en, rand_en;
  int    rdy_mode;
  bit    rdy_val;
  bit    out_lock_valid, out_lock_src, prev_stall;
  logic [162:0] held;
  int    r_acc_cnt, b_acc_cnt, r_first_acc, r_last_acc, b_first_acc, b_rdy_early, stall_seen;

  task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input bit src, input int nbeats, input logic [3:0] cid, input logic [12:0] bn);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.keep = 16'($urandom);
      b.last = (i == nbeats - 1);
      b.cid  = cid;
      b.bn   = bn;
      if (src) begin b_q.push_back(b); b_exp.push_back(b); end
      else     begin r_q.push_back(b); r_exp.push_back(b); end
    end
  endtask

  task automatic drive_inputs();
    if (r_en && r_q.size() > 0) begin
      r_channel_valid = 1'b1;
      {r_channel, r_channel_keep, r_channel_last, r_channel_connection_id, r_channel_byte_num} = r_q[0];
    end else begin
      r_channel_valid = 1'b0;
      r_channel = {$urandom, $urandom, $urandom, $urandom};
    end
    if (b_en && b_q.size() > 0) begin
      b_channel_valid = 1'b1;
      {b_channel, b_channel_keep, b_channel_last, b_channel_connection_id, b_channel_byte_num} = b_q[0];
    end else begin
      b_channel_valid = 1'b0;
      b_channel = {$urandom, $urandom, $urandom, $urandom};
    end
    if (rdy_mode == 1) tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    else               tx_ready = rdy_val;
  endtask

  task automatic monitor();
    beat_t cur;
    cur = {tx_data, tx_keep, tx_last, tx_connection_id, tx_byte_num};
    if (prev_stall) checkOutput("stall_hold", {cur, tx_src, tx_valid}, {held, 1'b1});
    if (tx_valid && tx_ready) begin
      if (out_lock_valid) checkOutput("no_interleave", tx_src, out_lock_src);
      if (tx_src == 1'b0) begin
        checkOutput("r_exp_avail", r_exp.size() > 0, 1);
        if (r_exp.size() > 0) begin checkOutput("r_beat", cur, r_exp[0]); void'(r_exp.pop_front()); end
      end else begin
        checkOutput("b_exp_avail", b_exp.size() > 0, 1);
        if (b_exp.size() > 0) begin checkOutput("b_beat", cur, b_exp[0]); void'(b_exp.pop_front()); end
      end
      out_lock_valid = !tx_last;
      out_lock_src   = tx_src;
      out_src.push_back(int'(tx_src));
      out_cyc.push_back(cyc);
    end
    prev_stall = tx_valid && !tx_ready;
    held = {cur, tx_src};
  endtask

  // One clock: sample/check at negedge, then move the drivers just after the active edge.
  task automatic applyStimulus();
    bit r_acc, b_acc;
    @(negedge clk);
    monitor();
    r_acc = r_channel_valid && r_channel_ready;
    b_acc = b_channel_valid && b_channel_ready;
    if (b_channel_ready && r_acc_cnt < 4) b_rdy_early++;
    if (tx_valid && !tx_ready) stall_seen++;
    if (r_acc) begin
      r_acc_cnt++;
      if (r_acc_cnt == 1) r_first_acc = cyc;
      if (r_channel_last) r_last_acc = cyc;
    end
    if (b_acc) begin
      b_acc_cnt++;
      if (b_acc_cnt == 1) b_first_acc = cyc;
    end
    @(posedge clk);
    #1;
    if (r_acc) void'(r_q.pop_front());
    if (b_acc) void'(b_q.pop_front());
    cyc++;
    if (rand_en) begin
      r_en = ($urandom % 10) < 7;
      b_en = ($urandom % 10) < 7;
    end
    drive_inputs();
  endtask

  task automatic clear_tracking();
    out_src.delete(); out_cyc.delete();
    r_acc_cnt = 0; b_acc_cnt = 0; r_first_acc = -1; r_last_acc = -1; b_first_acc = -1;
    b_rdy_early = 0; stall_seen = 0;
  endtask

  task automatic do_reset(input bit check_state);
    reset = 1'b1;
    r_en = 0; b_en = 0; rand_en = 0;
    r_q.delete(); b_q.delete(); r_exp.delete(); b_exp.delete();
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (check_state) begin
      checkOutput("rst_tx_valid", tx_valid, 0);
      checkOutput("rst_tx_fields", {tx_data, tx_keep, tx_last, tx_connection_id, tx_byte_num, tx_src}, 0);
      checkOutput("rst_r_ready", r_channel_ready, 0);
      checkOutput("rst_b_ready", b_channel_ready, 0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    prev_stall = 0; out_lock_valid = 0; out_lock_src = 0;
    clear_tracking();
  endtask

  task automatic run_drained(input string tag, input int max_cycles);
    int n = 0;
    while ((r_exp.size() > 0 || b_exp.size() > 0) && n < max_cycles) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, n < max_cycles, 1);
  endtask

  initial begin
    int n;
    int total_beats;
    rdy_mode = 0; rdy_val = 1'b1;
    do_reset(1'b1);

    // Single 3-beat R packet, one cycle of latency, back-to-back output beats.
    add_pkt(1'b0, 3, 4'd5, 13'd40);
    r_en = 1; drive_inputs();
    run_drained("t1_timeout", 50);
    checkOutput("t1_beats", out_cyc.size(), 3);
    if (out_cyc.size() == 3) begin
      checkOutput("t1_latency", out_cyc[0], r_first_acc + 1);
      checkOutput("t1_beat2_cyc", out_cyc[1], out_cyc[0] + 1);
      checkOutput("t1_beat3_cyc", out_cyc[2], out_cyc[0] + 2);
      checkOutput("t1_src", out_src[0] + out_src[1] + out_src[2], 0);
    end

    // Alternating R/B packets from reset with no idle cycles between them.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      add_pkt(1'b0, 2, 4'($urandom), 13'($urandom));
      add_pkt(1'b1, 1, 4'($urandom), 13'($urandom));
    end
    r_en = 1; b_en = 1; drive_inputs();
    run_drained("t2_timeout", 100);
    checkOutput("t2_beats", out_src.size(), 12);
    if (out_src.size() == 12) begin
      for (int i = 0; i < 12; i++) checkOutput("t2_order", out_src[i], ((i % 3) == 2) ? 1 : 0);
      for (int i = 1; i < 12; i++) checkOutput("t2_no_bubble", out_cyc[i] - out_cyc[i-1], 1);
    end

    // R packet stalls mid-packet upstream; B must wait for R's last beat.
    do_reset(1'b0);
    add_pkt(1'b0, 4, 4'd3, 13'd64);
    add_pkt(1'b1, 1, 4'd9, 13'd16);
    r_en = 1; b_en = 1; drive_inputs();
    n = 0;
    while (r_acc_cnt < 2 && n < 50) begin applyStimulus(); n++; end
    checkOutput("t3_r_start_timeout", n < 50, 1);
    r_en = 0; drive_inputs();
    repeat (3) applyStimulus();
    r_en = 1; drive_inputs();
    n = 0;
    while (b_acc_cnt == 0 && n < 50) begin applyStimulus(); n++; end
    checkOutput("t3_b_timeout", n < 50, 1);
    checkOutput("t3_b_ready_early", b_rdy_early, 0);
    checkOutput("t3_r_done_first", r_acc_cnt, 4);
    checkOutput("t3_b_next", b_first_acc, r_last_acc + 1);
    run_drained("t3_drain_timeout", 50);

    // Random mixed traffic with tx_ready pattern 1,0,0,1.
    do_reset(1'b0);
    total_beats = 0;
    for (int i = 0; i < 50; i++) begin
      bit src;
      int nb;
      src = 1'($urandom % 2);
      nb  = src ? ((($urandom % 4) == 0) ? 2 : 1) : 1 + int'($urandom % 4);
      total_beats += nb;
      add_pkt(src, nb, 4'($urandom), 13'($urandom));
    end
    rdy_mode = 1; rand_en = 1; r_en = 1; b_en = 1; drive_inputs();
    run_drained("t4_timeout", 4000);
    checkOutput("t4_beats", out_src.size(), total_beats);
    rdy_mode = 0; rand_en = 0; rdy_val = 1;

    // Asynchronous reset in the middle of an R packet.
    do_reset(1'b0);
    add_pkt(1'b0, 4, 4'd7, 13'd100);
    r_en = 1; drive_inputs();
    n = 0;
    while (r_acc_cnt < 2 && n < 50) begin applyStimulus(); n++; end
    checkOutput("t5_start_timeout", n < 50, 1);
    #3 reset = 1'b1;
    #1;
    checkOutput("t5_tx_valid", tx_valid, 0);
    checkOutput("t5_r_ready", r_channel_ready, 0);
    checkOutput("t5_b_ready", b_channel_ready, 0);
    r_q.delete(); r_exp.delete(); b_q.delete(); b_exp.delete();
    r_en = 0; drive_inputs();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    prev_stall = 0; out_lock_valid = 0;
    clear_tracking();
    add_pkt(1'b0, 2, 4'd1, 13'd20);
    add_pkt(1'b1, 1, 4'd2, 13'd8);
    r_en = 1; b_en = 1; drive_inputs();
    run_drained("t5_timeout", 50);
    checkOutput("t5_beats", out_src.size(), 3);
    if (out_src.size() == 3) begin
      checkOutput("t5_first_src", out_src[0], 0);
      checkOutput("t5_third_src", out_src[2], 1);
    end

`ifdef M_INTER_TX_ARB_STATS_EN
    // Packet and stall counters.
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) add_pkt(1'b0, 1 + int'($urandom % 3), 4'($urandom), 13'($urandom));
    for (int i = 0; i < 3; i++) add_pkt(1'b1, 1, 4'($urandom), 13'($urandom));
    r_en = 1; b_en = 1; drive_inputs();
    run_drained("t6_timeout", 200);
    checkOutput("t6_r_pkt_cnt", r_pkt_cnt, 7);
    checkOutput("t6_b_pkt_cnt", b_pkt_cnt, 3);
    checkOutput("t6_stall_zero", stall_cnt, 0);
    rdy_val = 0;
    add_pkt(1'b0, 1, 4'd4, 13'd12);
    drive_inputs();
    stall_seen = 0;
    n = 0;
    while (stall_seen < 10 && n < 50) begin applyStimulus(); n++; end
    checkOutput("t6_stall_timeout", n < 50, 1);
    checkOutput("t6_stall_cnt", stall_cnt, 10);
    rdy_val = 1; drive_inputs();
    run_drained("t6_drain_timeout", 20);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
